fb_writer: RTL and testbench

Write-side front end for the game's video memory. Accepts single-pixel draw requests over a valid/ready handshake, buffers them in a small FIFO, converts (x, y) to a linear address, and drives the write port of a dual-port framebuffer whose read port feeds the display path. Also performs a hardware full-screen clear, one pixel per clock.

---
 rtl/fb_writer.sv | 162 ++++++++++++++++
 tb/tb_fb_writer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_writer.sv
// Pixel write front end: request FIFO, (x,y)->linear address, framebuffer write port, full-screen clear.
// Optional range check on request coordinates when FB_WRITER_BOUNDS_CHECK_EN is defined.
module fb_writer #(
    parameter int DATA_WIDTH = 13,
    parameter int ADDR_WIDTH = 15,
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [X_WIDTH-1:0]    req_x,
    input  logic [Y_WIDTH-1:0]    req_y,
    input  logic [DATA_WIDTH-1:0] req_color,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_color,
    output logic                  busy,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  oob_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int PIXELS  = H_RES * V_RES;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIXELS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]   clr_color_q, clr_color_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];

    logic                    accept, start_clear, push, pop, in_range;
    logic [ADDR_WIDTH-1:0]   req_addr;

    assign req_addr    = ADDR_WIDTH'(req_y) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(req_x);
    assign accept      = req_valid && req_ready_q;
    assign start_clear = clear_start && (state_q == IDLE);
    // A request accepted on the clear_start edge is flushed along with the FIFO contents.
    assign push        = accept && in_range && !start_clear;
    assign pop         = (state_q == IDLE) && !start_clear && (count_q != '0);

`ifdef FB_WRITER_BOUNDS_CHECK_EN
    logic oob_err_q, oob_err_d;

    assign in_range = (32'(req_x) < 32'(H_RES)) && (32'(req_y) < 32'(V_RES));

    always_comb begin
        oob_err_d = oob_err_q | (accept & ~in_range);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) oob_err_q <= 1'b0;
        else     oob_err_q <= oob_err_d;
    end

    assign oob_err = oob_err_q;
`else
    assign in_range = 1'b1;
    assign oob_err  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        busy_d      = 1'b0;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                if (start_clear) begin
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
                    clr_color_d = clear_color;
                end else if (pop) begin
                    we_d               = 1'b1;
                    {waddr_d, wdata_d} = mem_q[rd_ptr_q];
                end
            end
            CLEAR: begin
                busy_d    = 1'b1;
                we_d      = 1'b1;
                waddr_d   = clr_cnt_q;
                wdata_d   = clr_color_q;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_PIX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        // Registered ready reflects the occupancy the FIFO will hold after this edge.
        req_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_addr, req_color};
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: expected writes queued at acceptance, checked as we/waddr/wdata appear.
module tb_fb_writer;

    localparam int DW = 13;
    localparam int AW = 15;
    localparam int H  = 160;
    localparam int V  = 120;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [7:0]    req_x = '0;
    logic [6:0]    req_y = '0;
    logic [DW-1:0] req_color = '0;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_color = '0;
    logic          busy, we, oob_err;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [AW+DW-1:0] sb [$];
    bit mon_en = 1'b0;

    fb_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_RES(H), .V_RES(V),
        .X_WIDTH(8), .Y_WIDTH(7), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .clear_start(clear_start), .clear_color(clear_color),
        .busy(busy), .we(we), .waddr(waddr), .wdata(wdata), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int x, input int y);
        return AW'((y * H + x) % (1 << AW));
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst && we) begin
            if (sb.size() == 0) begin
                check("extra_we", {31'd0, we}, 32'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = sb.pop_front();
                check("waddr", 32'(waddr), 32'(e[AW+DW-1:DW]));
                check("wdata", 32'(wdata), 32'(e[DW-1:0]));
            end
        end
    end

    // Presents one request from a negedge; returns just after the accepting posedge.
    task automatic send_px(input int x, input int y, input logic [DW-1:0] c, input bit exp_write);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_x = 8'(x);
        req_y = 7'(y);
        req_color = c;
        for (int t = 0; t < 50; t++) begin
            ok = req_ready;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
        else if (exp_write) sb.push_back({addr_of(x, y), c});
    endtask

    task automatic drain(input string tag, input int budget);
        for (int t = 0; t < budget; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin
        int cnt, acc;
        bit found;
        int xs [8] = '{0, 159, 0, 159, 17, 80, 42, 123};
        int ys [8] = '{0, 0, 119, 119, 33, 60, 101, 7};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_we",    {31'd0, we}, 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_oob",   {31'd0, oob_err}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Single pixel with latency check
        send_px(3, 2, 13'h1ABC, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        check("lat_we0", {31'd0, we}, 32'd0);
        @(negedge clk);
        check("lat_we1", {31'd0, we}, 32'd1);
        check("lat_addr", 32'(waddr), 32'd323);
        @(negedge clk);
        check("after_we", {31'd0, we}, 32'd0);
        drain("drain_single", 20);

        // Back-to-back stream: corners plus interior points, random colours
        for (int i = 0; i < 8; i++) send_px(xs[i], ys[i], DW'($urandom), 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        drain("drain_stream", 50);

        // Out-of-range column
`ifdef FB_WRITER_BOUNDS_CHECK_EN
        send_px(160, 0, 13'h0123, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("oob_err_set", {31'd0, oob_err}, 32'd1);
        send_px(5, 5, 13'h0F0F, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        drain("drain_oob", 20);
        check("oob_err_held", {31'd0, oob_err}, 32'd1);
`else
        send_px(160, 0, 13'h0123, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        drain("drain_oob", 20);
        check("oob_err_zero", {31'd0, oob_err}, 32'd0);
`endif

        // Clear A (colour 0); three pixels queued during it must be flushed by clear B
        @(negedge clk);
        clear_color = '0;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        check("clr_busy_lag", {31'd0, busy}, 32'd0);
        for (int i = 0; i < NPIX; i++) sb.push_back({AW'(i), DW'(0)});
        cnt = 0;
        found = 1'b0;
        for (int k = 0; k < NPIX + 100; k++) begin
            @(negedge clk);
            if (busy) cnt++;
            if (k >= 100 && k <= 102) begin
                req_valid = 1'b1;
                req_x = 8'(10 + k);
                req_y = 7'(k - 90);
                req_color = 13'h1555;
            end else begin
                req_valid = 1'b0;
            end
            if (k == 103) check("flush_ready3", {31'd0, req_ready}, 32'd1);
            if (we && waddr == AW'(NPIX - 1)) begin
                found = 1'b1;
                break;
            end
        end
        check("clr_found_last", {31'd0, found}, 32'd1);
        check("busy_len", cnt, NPIX);

        // Clear B started on the edge where the three pixels would begin draining
        clear_color = 13'h0555;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        check("flush_we", {31'd0, we}, 32'd0);
        for (int i = 0; i < NPIX; i++) sb.push_back({AW'(i), DW'(13'h0555)});

        // Six requests offered one per cycle regardless of ready while clear B runs
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bit r;
            @(negedge clk);
            req_valid = 1'b1;
            req_x = 8'(20 + i);
            req_y = 7'(50 + i);
            req_color = DW'(13'h0100 + i);
            r = req_ready;
            @(posedge clk);
            if (r) begin
                acc++;
                sb.push_back({addr_of(20 + i, 50 + i), DW'(13'h0100 + i)});
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_accepted", acc, 32'd4);
        check("bp_ready_low", {31'd0, req_ready}, 32'd0);
        drain("drain_clear_b", NPIX + 200);
        @(negedge clk);
        check("post_clear_busy", {31'd0, busy}, 32'd0);

        // Clear C interrupted by reset at waddr 5000
        mon_en = 1'b0;
        clear_color = 13'h1FFF;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (we && waddr == AW'(5000)) begin
                found = 1'b1;
                break;
            end
        end
        check("midclr_found", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_we",    {31'd0, we}, 32'd0);
        check("arst_busy",  {31'd0, busy}, 32'd0);
        check("arst_waddr", 32'(waddr), 32'd0);
        check("arst_wdata", 32'(wdata), 32'd0);
        check("arst_ready", {31'd0, req_ready}, 32'd0);
        check("arst_oob",   {31'd0, oob_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        mon_en = 1'b1;
        send_px(5, 7, 13'h0ABC, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        drain("drain_after_rst", 20);
        repeat (10) @(negedge clk);
        check("no_resume_busy", {31'd0, busy}, 32'd0);
        check("no_resume_we",   {31'd0, we}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
